demux_1x4_reg: RTL
==================

# demux_1x4_reg

Registered 1-to-4 demultiplexer with valid/ready handshakes: accepts one WIDTH-bit word per cycle on a single input lane and steers it into one of four output lanes, selected either by an explicit select input or by an internal round-robin pointer. Each output lane has a one-entry holding register, so a stalled lane back-pressures the input only when that lane is targeted. It is the distribution counterpart to the team's 4-to-1 selection path, fanning one stream out to four consumers.

## Interface
- WIDTH, 4, data width of input and each output lane
- clk  input  1  clock; all state updates on rising edge
- reset_L  input  1  synchronous, active-low reset
- en  input  1  block enable; 0 blocks acceptance of new input words
- valid_in  input  1  data_in holds a word to transfer
- data_in  input  WIDTH  input word
- sel  input  2  target lane when rr_mode=0
- rr_mode  input  1  1: target lane from internal round-robin pointer; 0: from sel
- ready_in  output  1  block can accept a word this cycle (combinational)
- data_out0..data_out3  output  WIDTH each  lane holding registers
- valid_out0..valid_out3  output  1 each  lane register holds an undelivered word
- ready_out0..ready_out3  input  1 each  downstream consumer of lane i takes the word this cycle
- rr_ptr  output  2  current round-robin pointer (observability)

## Operation
- Target lane t = rr_mode ? rr_ptr : sel, evaluated combinationally each cycle.
- lane_free[i] = !valid_out[i] || ready_out[i].
- ready_in = en && lane_free[t]; independent of valid_in.
- Input accept: acc = valid_in && ready_in.
- Output deliver on lane i: valid_out[i] && ready_out[i].
- On acc: data_out[t] <= data_in; valid_out[t] <= 1.
- For every lane i ≠ t (or any lane when !acc): if delivered, valid_out[i] <= 0; data_out[i] holds its last value (not cleared).
- Same lane delivered and refilled in one cycle: valid_out[t] stays 1, data_out[t] takes the new word; no bubble.
- rr_ptr: on acc with rr_mode=1, rr_ptr <= rr_ptr + 1 mod 4 (3 wraps to 0). Otherwise holds. Switching rr_mode does not reset rr_ptr.
- en=0: no acceptance; lanes still drain normally; rr_ptr holds.
- Data not modified; no reordering within a lane. Words to different lanes are independent.
- No state machine beyond the four lane valid bits and rr_ptr.

## Timing
- Reset (reset_L=0 at rising edge): all data_outN = 0, all valid_outN = 0, rr_ptr = 0. ready_in follows its combinational definition (1 when en=1, since all lanes empty). Reset overrides any concurrent accept or deliver; words held in lanes are discarded.
- Latency: word accepted at edge k appears on data_out[t] with valid_out[t]=1 immediately after edge k (1 cycle).
- Throughput: 1 word/cycle sustained while target lane is free or draining each cycle.
- Back-pressure: lane t full and ready_out[t]=0 → ready_in=0; valid_in/data_in must be held by the source; no word lost or duplicated.
- A blocked lane never blocks a word targeting a different lane (sel change or rr_ptr already pointing elsewhere).
- In rr_mode a stalled target lane stalls the whole input; pointer does not skip full lanes.
- valid_out[i] once asserted stays 1 and data_out[i] stays stable until delivered.

## Test plan
- Reset then idle: after reset_L=0 for one edge, all data_outN=0, valid_outN=0, rr_ptr=0, ready_in=1 with en=1.
- Explicit routing: rr_mode=0, all ready_out=1, send 0xA,0x5,0xC,0x3 with sel=0,1,2,3 on consecutive cycles → each appears on lane 0..3 one cycle later, valid pulses for one cycle each.
- Back-pressure: ready_out2=0, send 0x7 then 0x9 both sel=2 → lane 2 holds 0x7, ready_in=0 for second word until ready_out2=1, then 0x9 loads the following edge with valid_out2 staying 1; 0x9 never lost; meanwhile a word with sel=1 is accepted.
- Round-robin wrap: rr_mode=1, all ready, send 6 words 0x1..0x6 → lanes 0,1,2,3,0,1; rr_ptr sequence 0,1,2,3,0,1,2.
- Enable gating: en=0 with valid_in=1 for 3 cycles → ready_in=0, no lane loads, rr_ptr unchanged; pre-filled lanes still drain when ready_out asserted.
- Reset mid-operation: lanes 0 and 3 full, ready_out=0, assert reset_L=0 with valid_in=1 → all valid_outN=0, data_outN=0, rr_ptr=0; nothing accepted that cycle.

Source files
------------

// File: rtl/demux_1x4_reg.sv
// Registered 1-to-4 demultiplexer with valid/ready handshakes.
// One holding register per lane; lane target from sel or a round-robin pointer.
module demux_1x4_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             en,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic [1:0]       sel,
    input  logic             rr_mode,
    output logic             ready_in,
    output logic [WIDTH-1:0] data_out0,
    output logic [WIDTH-1:0] data_out1,
    output logic [WIDTH-1:0] data_out2,
    output logic [WIDTH-1:0] data_out3,
    output logic             valid_out0,
    output logic             valid_out1,
    output logic             valid_out2,
    output logic             valid_out3,
    input  logic             ready_out0,
    input  logic             ready_out1,
    input  logic             ready_out2,
    input  logic             ready_out3,
    output logic [1:0]       rr_ptr
);

    logic [WIDTH-1:0] r_data [4];
    logic [3:0]       r_valid;
    logic [1:0]       r_ptr;

    logic [1:0]       w_tgt;
    logic [3:0]       w_rdy;
    logic [3:0]       w_free;
    logic             w_acc;

    assign w_rdy  = {ready_out3, ready_out2, ready_out1, ready_out0};
    assign w_tgt  = rr_mode ? r_ptr : sel;
    assign w_free = ~r_valid | w_rdy;

    // ready_in deliberately ignores valid_in so sources may wait on it
    assign ready_in = en && w_free[w_tgt];
    assign w_acc    = valid_in && ready_in;

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            for (int i = 0; i < 4; i++) begin
                r_data[i] <= '0;
            end
            r_valid <= '0;
            r_ptr   <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_acc && (w_tgt == 2'(i))) begin
                    r_data[i]  <= data_in;
                    r_valid[i] <= 1'b1;
                end else if (r_valid[i] && w_rdy[i]) begin
                    r_valid[i] <= 1'b0;
                end
            end
            if (w_acc && rr_mode) begin
                r_ptr <= r_ptr + 2'd1;
            end
        end
    end

    assign data_out0  = r_data[0];
    assign data_out1  = r_data[1];
    assign data_out2  = r_data[2];
    assign data_out3  = r_data[3];
    assign valid_out0 = r_valid[0];
    assign valid_out1 = r_valid[1];
    assign valid_out2 = r_valid[2];
    assign valid_out3 = r_valid[3];
    assign rr_ptr     = r_ptr;

endmodule
